// File: rtl/uart_tx_unit.sv
// uart_tx_unit: 8-bit async UART transmitter (start, 8 data LSB first, optional parity, 1-2 stop) with dataSent ack pulse, busy flag and frame counter
module uart_tx_unit #(
  parameter int CLKS_PER_BIT = 868,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] dataToSend,
  input  logic       writeFlag,
  input  logic       notStartTrans,
  output logic       tx,
  output logic       dataSent,
  output logic       txBusy,
  output logic [7:0] sentCount
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic PAR_EN = (PARITY == 1) || (PARITY == 2);
  localparam logic PAR_ODD = PARITY == 2;
  localparam logic [2:0] LAST_STOP = (STOP_BITS == 2) ? 3'd1 : 3'd0;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] data_q, data_d;
  logic [7:0] count_q, count_d;
  logic tx_q, tx_d;
  logic sent_q, sent_d;
  logic busy_q, busy_d;
  logic last;
  always_comb begin
    last = cnt_q == CNT_MAX;
    state_d = state_q;
    cnt_d = (state_q == IDLE || state_q == DONE || last) ? '0 : cnt_q + CW'(1);
    idx_d = idx_q;
    data_d = data_q;
    count_d = count_q;
    tx_d = tx_q;
    sent_d = 1'b0;
    busy_d = busy_q;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (writeFlag && !notStartTrans) begin
          state_d = START;
          data_d = dataToSend;
          tx_d = 1'b0;
          busy_d = 1'b1;
        end
      end
      START: if (last) begin
        state_d = DATA;
        idx_d = 3'd0;
        tx_d = data_q[0];
      end
      DATA: if (last) begin
        idx_d = (idx_q == 3'd7) ? 3'd0 : idx_q + 3'd1;
        state_d = (idx_q != 3'd7) ? DATA : PAR_EN ? PAR : STOP;
        tx_d = (idx_q != 3'd7) ? data_q[idx_q + 3'd1] : PAR_EN ? (^data_q) ^ PAR_ODD : 1'b1;
      end
      PAR: if (last) begin
        state_d = STOP;
        tx_d = 1'b1;
      end
      STOP: if (last) begin
        idx_d = (idx_q == LAST_STOP) ? 3'd0 : idx_q + 3'd1;
        state_d = (idx_q == LAST_STOP) ? DONE : STOP;
        sent_d = idx_q == LAST_STOP;
        count_d = (idx_q == LAST_STOP) ? count_q + 8'd1 : count_q;
      end
      DONE: begin
        state_d = IDLE;
        tx_d = 1'b1;
        busy_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      idx_q <= 3'd0;
      data_q <= 8'd0;
      count_q <= 8'd0;
      tx_q <= 1'b1;
      sent_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      data_q <= data_d;
      count_q <= count_d;
      tx_q <= tx_d;
      sent_q <= sent_d;
      busy_q <= busy_d;
    end
  end
  assign tx = tx_q;
  assign dataSent = sent_q;
  assign txBusy = busy_q;
  assign sentCount = count_q;
endmodule

// File: tb/tb_uart_tx_unit.sv
// tb_uart_tx_unit: directed self-checking bench for uart_tx_unit in 8N1 and 8O2 configurations
module tb_uart_tx_unit;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [7:0] d0 = 8'd0, d1 = 8'd0;
  logic w0 = 1'b0, w1 = 1'b0, n0 = 1'b0, n1 = 1'b0;
  logic tx0, ds0, bz0, tx1, ds1, bz1;
  logic [7:0] sc0, sc1;
  int checks = 0;
  int errors = 0;
  always #5 clock = ~clock;
  uart_tx_unit #(.CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(1)) u0 (
    .clock(clock), .reset(reset), .dataToSend(d0), .writeFlag(w0), .notStartTrans(n0),
    .tx(tx0), .dataSent(ds0), .txBusy(bz0), .sentCount(sc0)
  );
  uart_tx_unit #(.CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(2)) u1 (
    .clock(clock), .reset(reset), .dataToSend(d1), .writeFlag(w1), .notStartTrans(n1),
    .tx(tx1), .dataSent(ds1), .txBusy(bz1), .sentCount(sc1)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic frame(input bit sel, input logic [11:0] bits, input int nb, input bit keep, input logic [7:0] nxt, input string tag);
    for (int n = 0; n <= nb * 4; n++) begin
      @(negedge clock);
      if (n < nb * 4) begin
        chk({tag, " tx"}, sel ? tx1 : tx0, bits[n / 4]);
        chk({tag, " dataSent low"}, sel ? ds1 : ds0, 1'b0);
      end else begin
        chk({tag, " dataSent pulse"}, sel ? ds1 : ds0, 1'b1);
        chk({tag, " done tx"}, sel ? tx1 : tx0, 1'b1);
        if (sel) w1 = 1'b0;
        else if (keep) d0 = nxt;
        else w0 = 1'b0;
      end
      chk({tag, " busy"}, sel ? bz1 : bz0, 1'b1);
    end
    @(negedge clock);
    chk({tag, " idle tx"}, sel ? tx1 : tx0, 1'b1);
    chk({tag, " idle dataSent"}, sel ? ds1 : ds0, 1'b0);
    chk({tag, " idle busy"}, sel ? bz1 : bz0, 1'b0);
  endtask
  initial begin
    repeat (3) @(negedge clock);
    chk("reset tx", tx0, 1'b1);
    chk("reset dataSent", ds0, 1'b0);
    chk("reset busy", bz0, 1'b0);
    chk("reset count", sc0, 8'd0);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      chk("idle tx", tx0, 1'b1);
      chk("idle dataSent", ds0, 1'b0);
      chk("idle busy", bz0, 1'b0);
      chk("idle count", sc0, 8'd0);
    end
    d0 = 8'hA5;
    w0 = 1'b1;
    @(posedge clock);
    frame(1'b0, {2'b00, 1'b1, 8'hA5, 1'b0}, 10, 1'b0, 8'd0, "a5");
    chk("a5 count", sc0, 8'd1);
    d1 = 8'h03;
    w1 = 1'b1;
    @(posedge clock);
    frame(1'b1, {1'b1, 1'b1, 1'b1, 8'h03, 1'b0}, 12, 1'b0, 8'd0, "odd2stop");
    chk("odd2stop count", sc1, 8'd1);
    d0 = 8'h3C;
    w0 = 1'b1;
    n0 = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      chk("holdoff tx", tx0, 1'b1);
      chk("holdoff busy", bz0, 1'b0);
    end
    n0 = 1'b0;
    @(posedge clock);
    #1;
    n0 = 1'b1;
    d0 = 8'hFF;
    frame(1'b0, {2'b00, 1'b1, 8'h3C, 1'b0}, 10, 1'b0, 8'd0, "holdoff");
    chk("holdoff count", sc0, 8'd2);
    n0 = 1'b0;
    d0 = 8'h55;
    w0 = 1'b1;
    @(posedge clock);
    repeat (17) @(negedge clock);
    chk("midreset bit3", tx0, 1'b0);
    reset = 1'b1;
    w0 = 1'b0;
    @(negedge clock);
    chk("midreset tx", tx0, 1'b1);
    chk("midreset dataSent", ds0, 1'b0);
    chk("midreset busy", bz0, 1'b0);
    chk("midreset count", sc0, 8'd0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("postreset dataSent", ds0, 1'b0);
      chk("postreset tx", tx0, 1'b1);
    end
    d0 = 8'h81;
    w0 = 1'b1;
    @(posedge clock);
    frame(1'b0, {2'b00, 1'b1, 8'h81, 1'b0}, 10, 1'b0, 8'd0, "postreset");
    chk("postreset count", sc0, 8'd1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    d0 = 8'd0;
    w0 = 1'b1;
    for (int i = 0; i < 95; i++) begin
      @(posedge clock);
      frame(1'b0, {2'b00, 1'b1, 8'(i), 1'b0}, 10, i < 94, 8'(i + 1), "stream");
    end
    chk("stream count", sc0, 8'd95);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_tx_unit.md
Name: uart_tx_unit

Overview:
- Serial transmit stage directly downstream of the debug unit.
- Consumes the debug unit's byte stream (data, write flag, start hold-off) and serialises each byte onto the board UART TX pin as 8-bit async frames.
- Returns a one-cycle `dataSent` pulse per completed frame; the debug unit uses that pulse to advance its byte counter and present the next byte.
- Level-based valid/ack handshake: the producer holds the byte until `dataSent`.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); legal range 2..65535.
- PARITY, 0, 0 = none, 1 = even, 2 = odd; any other value behaves as 0.
- STOP_BITS, 1, number of stop bits, 1 or 2.

Ports:
- clock  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high; sampled on rising edge of clock.
- dataToSend  input  8  byte to transmit; must be stable while writeFlag is high and the block is not idle.
- writeFlag  input  1  level "byte valid" from producer.
- notStartTrans  input  1  hold-off; when high, no new frame may start.
- tx  output  1  serial line, idle high.
- dataSent  output  1  one-cycle pulse: current frame fully transmitted (ack).
- txBusy  output  1  high from accept edge until the end of the DONE cycle.
- sentCount  output  8  completed-frame counter, wraps 255 -> 0.

Behaviour:
- Reset values (next edge with reset = 1): tx = 1, dataSent = 0, txBusy = 0, sentCount = 0, state = IDLE, all internal counters 0.
- Reset mid-frame aborts the frame: tx = 1 next cycle, no dataSent pulse, sentCount unchanged from its reset value 0.
- States: IDLE, START, DATA, PARITY, STOP, DONE; all outputs are registered.
- IDLE:
  - tx = 1.
  - If writeFlag = 1 and notStartTrans = 0 at an edge (the accept edge), latch dataToSend into the shift register and go to START; txBusy = 1 from this edge.
  - Otherwise stay in IDLE.
- START: tx = 0 for exactly CLKS_PER_BIT cycles, then go to DATA.
- DATA:
  - 8 bits, LSB first, each held CLKS_PER_BIT cycles.
  - Bit index 0..7; after bit 7 go to PARITY if PARITY ≠ 0, else to STOP.
- PARITY:
  - Even: tx = XOR of latched byte. Odd: tx = its inverse.
  - Held CLKS_PER_BIT cycles, then go to STOP.
- STOP: tx = 1 for STOP_BITS × CLKS_PER_BIT cycles, then go to DONE.
- DONE:
  - Lasts one cycle: dataSent = 1, tx = 1, sentCount increments.
  - Then go to IDLE; txBusy clears at the DONE → IDLE edge.
- Latency: dataSent is high in the cycle beginning F × CLKS_PER_BIT edges after the accept edge, where F = 1 + 8 + (PARITY ≠ 0) + STOP_BITS (10 for the default configuration).
- Back-to-back bytes:
  - The producer advances on the edge that samples dataSent = 1, so the next byte is valid in the following IDLE cycle.
  - That byte is accepted at the end of that cycle if writeFlag = 1 and notStartTrans = 0.
  - Minimum inter-frame idle-high time is therefore 2 cycles: DONE + IDLE.
- Mid-frame input changes:
  - Changes to dataToSend, writeFlag or notStartTrans after the accept edge are ignored; the frame always completes.
  - notStartTrans only gates acceptance in IDLE.
- writeFlag high in IDLE with notStartTrans high: no accept, tx stays 1, waits indefinitely.
- Baud counter:
  - Width ceil(log2(CLKS_PER_BIT)).
  - Counts 0..CLKS_PER_BIT−1 and reloads to 0 on every state change, so no cumulative drift.
- sentCount: at 255, DONE takes it to 0 (modulo 256).

Test Plan:
- Reset, then idle: with CLKS_PER_BIT = 4, PARITY = 0, hold reset 3 cycles then release → tx = 1, dataSent = 0, txBusy = 0, sentCount = 0 for 20 idle cycles.
- Single byte 0xA5 (CLKS_PER_BIT = 4): writeFlag = 1, notStartTrans = 0 → tx shows 0,1,0,1,0,0,1,0,1,1, each bit exactly 4 cycles; dataSent high exactly 1 cycle, 40 edges after the accept edge; sentCount = 1.
- Debug-unit-style stream: drive 95 bytes (0..94) with a producer that advances on dataSent → 95 dataSent pulses, every decoded frame matches its byte in order, 2-cycle idle gaps, sentCount = 95.
- Parity and stop bits: PARITY = 2, STOP_BITS = 2, byte 0x03 → parity bit 1 (odd), stop high for 8 cycles; dataSent 48 edges after accept.
- Hold-off: writeFlag = 1 with notStartTrans = 1 for 30 cycles → no start bit. Drop notStartTrans → frame starts on that edge. Raise notStartTrans mid-frame → frame still completes.
- Reset mid-frame: assert reset during DATA bit 3 → tx = 1 next cycle, no dataSent pulse, sentCount = 0. A new byte after release transmits correctly.
